// File: rtl/cmp_sort_engine.sv
// Sort engine: loads DEPTH words, bubble-sorts them with one shared comparator
// (one compare per clock, signed or unsigned), then streams them out ascending.
// Optional build macro CMP_SORT_EARLY_EXIT_EN stops sorting after a swap-free pass.
module cmp_sort_engine #(
    parameter int WIDTH = 6,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             signed_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last,
    output logic             busy,
    output logic [15:0]      cmp_count
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW-1:0] IDX_LAST = AW'(DEPTH - 1);
    localparam logic [AW-1:0] J_LAST   = AW'(DEPTH - 2);

    typedef enum logic [1:0] {ST_LOAD, ST_SORT, ST_OUT} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_idx_q, wr_idx_d;
    logic [AW-1:0]    rd_idx_q, rd_idx_d;
    logic [AW-1:0]    j_q, j_d;
    logic [AW-1:0]    pass_q, pass_d;
    logic             mode_q, mode_d;
    logic [15:0]      cnt_q, cnt_d;
`ifdef CMP_SORT_EARLY_EXIT_EN
    logic             swapped_q, swapped_d;
`endif

    // Shared comparator: A = mem[j], B = mem[j+1]; swap only when B < A strictly.
    logic [AW-1:0]    j_nxt;
    logic [WIDTH-1:0] cmp_a, cmp_b;
    logic             lt_ba, ltu_ba, eq_ab, do_swap, pass_end, sort_done;

    assign j_nxt   = j_q + 1'b1;
    assign cmp_a   = mem_q[j_q];
    assign cmp_b   = mem_q[j_nxt];
    assign lt_ba   = $signed(cmp_b) < $signed(cmp_a);
    assign ltu_ba  = cmp_b < cmp_a;
    assign eq_ab   = (cmp_a == cmp_b);
    assign do_swap = ~eq_ab & (mode_q ? lt_ba : ltu_ba);
    assign pass_end = (j_q == J_LAST);
`ifdef CMP_SORT_EARLY_EXIT_EN
    assign sort_done = pass_end & ((pass_q == J_LAST) | ~(swapped_q | do_swap));
`else
    assign sort_done = pass_end & (pass_q == J_LAST);
`endif

    // Handshakes: a word moves only on a cycle where valid && ready are both high;
    // data is held stable by the sender while valid is high and ready is low.
    assign in_ready  = (state_q == ST_LOAD);
    assign out_valid = (state_q == ST_OUT);
    assign out_data  = (state_q == ST_OUT) ? mem_q[rd_idx_q] : '0;
    assign out_last  = (state_q == ST_OUT) && (rd_idx_q == IDX_LAST);
    assign busy      = (state_q != ST_LOAD);
    assign cmp_count = cnt_q;

    always_comb begin
        state_d  = state_q;
        mem_d    = mem_q;
        wr_idx_d = wr_idx_q;
        rd_idx_d = rd_idx_q;
        j_d      = j_q;
        pass_d   = pass_q;
        mode_d   = mode_q;
        cnt_d    = cnt_q;
`ifdef CMP_SORT_EARLY_EXIT_EN
        swapped_d = swapped_q;
`endif
        unique case (state_q)
            ST_LOAD: begin
                if (in_valid) begin
                    mem_d[wr_idx_q] = in_data;
                    if (wr_idx_q == '0) begin
                        mode_d = signed_mode;
                        cnt_d  = '0;
                    end
                    if (wr_idx_q == IDX_LAST) begin
                        wr_idx_d = '0;
                        j_d      = '0;
                        pass_d   = '0;
                        state_d  = ST_SORT;
`ifdef CMP_SORT_EARLY_EXIT_EN
                        swapped_d = 1'b0;
`endif
                    end else begin
                        wr_idx_d = wr_idx_q + 1'b1;
                    end
                end
            end
            ST_SORT: begin
                if (do_swap) begin
                    mem_d[j_q]   = cmp_b;
                    mem_d[j_nxt] = cmp_a;
                end
                cnt_d = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
`ifdef CMP_SORT_EARLY_EXIT_EN
                swapped_d = pass_end ? 1'b0 : (swapped_q | do_swap);
`endif
                if (sort_done) begin
                    state_d  = ST_OUT;
                    rd_idx_d = '0;
                    j_d      = '0;
                end else if (pass_end) begin
                    j_d    = '0;
                    pass_d = pass_q + 1'b1;
                end else begin
                    j_d = j_nxt;
                end
            end
            ST_OUT: begin
                if (out_ready) begin
                    if (rd_idx_q == IDX_LAST) begin
                        rd_idx_d = '0;
                        wr_idx_d = '0;
                        state_d  = ST_LOAD;
                    end else begin
                        rd_idx_d = rd_idx_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_LOAD;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_LOAD;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_idx_q <= '0;
            rd_idx_q <= '0;
            j_q      <= '0;
            pass_q   <= '0;
            mode_q   <= 1'b0;
            cnt_q    <= '0;
`ifdef CMP_SORT_EARLY_EXIT_EN
            swapped_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
            wr_idx_q <= wr_idx_d;
            rd_idx_q <= rd_idx_d;
            j_q      <= j_d;
            pass_q   <= pass_d;
            mode_q   <= mode_d;
            cnt_q    <= cnt_d;
`ifdef CMP_SORT_EARLY_EXIT_EN
            swapped_q <= swapped_d;
`endif
        end
    end
endmodule

// File: tb/tb_cmp_sort_engine.sv
// Directed bench for cmp_sort_engine: load, sort latency, ordering, backpressure, reset.
`timescale 1ns/1ps
module tb_cmp_sort_engine;
    localparam int W = 6;
    localparam int D = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_data = '0;
    logic         signed_mode = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] out_data;
    logic         out_last;
    logic         busy;
    logic [15:0]  cmp_count;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] stim [D];
    logic [W-1:0] exp_q [$];

    cmp_sort_engine #(.WIDTH(W), .DEPTH(D)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .signed_mode(signed_mode),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .busy(busy), .cmp_count(cmp_count)
    );

    // clock / reset
    always #5 clk = ~clk;

    // driver: every word is accepted at the edge it is presented on (in_ready high in LOAD)
    task automatic load_batch(input logic m0, input logic mrest);
        out_ready = 1'b0;
        for (int i = 0; i < D; i++) begin
            in_valid    = 1'b1;
            in_data     = stim[i];
            signed_mode = (i == 0) ? m0 : mrest;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
    endtask

    // counts edges from the last accept edge (counted as 1) until out_valid shows
    task automatic wait_out(output int lat);
        lat = 1;
        in_valid  = 1'b1;
        in_data   = 6'h15;
        out_ready = 1'b1;
        for (int k = 0; k < 300 && !out_valid; k++) begin
            @(posedge clk); #1;
            lat++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        checks++;
        if (!out_valid) begin
            errors++;
            $display("FAIL wait_out_timeout: out_valid=%0b required 1", out_valid);
        end
    endtask

    task automatic drain(input bit bp);
        int  n_hs;
        bit  prev_stall;
        bit  done;
        logic [W-1:0] prev_data;
        logic [W-1:0] exp_w;
        n_hs = 0; prev_stall = 0; done = 0; prev_data = '0;
        in_valid = 1'b0;
        for (int k = 0; k < 200 && !done; k++) begin
            out_ready = bp ? ((k % 4 == 0) || (k % 4 == 3)) : 1'b1;
            if (prev_stall) begin
                checks++;
                if (out_data !== prev_data) begin
                    errors++;
                    $display("FAIL stall_stable: out_data=%0d required %0d", out_data, prev_data);
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            if (out_valid && out_ready) begin
                n_hs++;
                exp_w = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
                checks++;
                if (out_data !== exp_w) begin
                    errors++;
                    $display("FAIL out_data[%0d]: got %0d required %0d", n_hs - 1, out_data, exp_w);
                end
                checks++;
                if (out_last !== (exp_q.size() == 0)) begin
                    errors++;
                    $display("FAIL out_last[%0d]: got %0b required %0b", n_hs - 1, out_last, exp_q.size() == 0);
                end
                if (out_last) done = 1;
            end
            @(posedge clk); #1;
        end
        out_ready = 1'b0;
        checks++;
        if (n_hs != D || exp_q.size() != 0) begin
            errors++;
            $display("FAIL handshake_count: got %0d required %0d (left %0d)", n_hs, D, exp_q.size());
        end
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL back_to_load: in_ready=%0b out_valid=%0b busy=%0b required 1 0 0", in_ready, out_valid, busy);
        end
    endtask

    task automatic check_idle_outputs(input string name);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== '0 || out_last !== 1'b0 ||
            busy !== 1'b0 || cmp_count !== 16'd0) begin
            errors++;
            $display("FAIL %s: in_ready=%0b out_valid=%0b out_data=%0d out_last=%0b busy=%0b cmp_count=%0d required 1 0 0 0 0 0",
                     name, in_ready, out_valid, out_data, out_last, busy, cmp_count);
        end
    endtask

    task automatic set_stim(input logic [W-1:0] a0, a1, a2, a3, a4, a5, a6, a7);
        stim[0] = a0; stim[1] = a1; stim[2] = a2; stim[3] = a3;
        stim[4] = a4; stim[5] = a5; stim[6] = a6; stim[7] = a7;
    endtask

    task automatic push_exp(input logic [W-1:0] a0, a1, a2, a3, a4, a5, a6, a7);
        exp_q.delete();
        exp_q.push_back(a0); exp_q.push_back(a1); exp_q.push_back(a2); exp_q.push_back(a3);
        exp_q.push_back(a4); exp_q.push_back(a5); exp_q.push_back(a6); exp_q.push_back(a7);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs("reset_state");
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_idle_outputs("after_release");
    endtask

    task automatic test_unsigned;
        int lat;
        set_stim(63, 0, 5, 5, 32, 1, 2, 7);
        push_exp(0, 1, 2, 5, 5, 7, 32, 63);
        load_batch(1'b0, 1'b0);
        checks++;
        if (in_ready !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL enter_sort: in_ready=%0b busy=%0b required 0 1", in_ready, busy);
        end
        wait_out(lat);
`ifndef CMP_SORT_EARLY_EXIT_EN
        checks++;
        if (lat != 50) begin
            errors++;
            $display("FAIL unsigned_latency: got %0d required 50", lat);
        end
        checks++;
        if (cmp_count !== 16'd49) begin
            errors++;
            $display("FAIL unsigned_cmp_count: got %0d required 49", cmp_count);
        end
`endif
        drain(1'b0);
    endtask

    task automatic test_signed;
        int lat;
        set_stim(63, 0, 5, 5, 32, 1, 2, 7);
        push_exp(32, 63, 0, 1, 2, 5, 5, 7);
        load_batch(1'b1, 1'b1);
        wait_out(lat);
        drain(1'b0);
    endtask

    task automatic test_mode_latch;
        int lat;
        set_stim(63, 0, 5, 5, 32, 1, 2, 7);
        push_exp(32, 63, 0, 1, 2, 5, 5, 7);
        load_batch(1'b1, 1'b0);
        wait_out(lat);
        drain(1'b0);
    endtask

    task automatic test_backpressure;
        int lat;
        set_stim(9, 40, 3, 17, 3, 60, 0, 33);
        push_exp(0, 3, 3, 9, 17, 33, 40, 60);
        load_batch(1'b0, 1'b0);
        wait_out(lat);
        drain(1'b1);
    endtask

    task automatic test_reset_mid_sort;
        int lat;
        set_stim(8, 7, 6, 5, 4, 3, 2, 1);
        load_batch(1'b0, 1'b0);
        repeat (19) begin @(posedge clk); #1; end
        checks++;
        if (busy !== 1'b1 || cmp_count !== 16'd19) begin
            errors++;
            $display("FAIL mid_sort: busy=%0b cmp_count=%0d required 1 19", busy, cmp_count);
        end
        rst_n = 1'b0;
        #1;
        check_idle_outputs("async_reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_idle_outputs("reset_release");
        push_exp(1, 2, 3, 4, 5, 6, 7, 8);
        load_batch(1'b0, 1'b0);
        wait_out(lat);
        checks++;
        if (lat != 50 || cmp_count !== 16'd49) begin
            errors++;
            $display("FAIL reversed_timing: lat=%0d cmp_count=%0d required 50 49", lat, cmp_count);
        end
        drain(1'b0);
    endtask

    task automatic test_early_exit;
        int lat;
        int exp_lat;
        logic [15:0] exp_cnt;
`ifdef CMP_SORT_EARLY_EXIT_EN
        exp_lat = 8;  exp_cnt = 16'd7;
`else
        exp_lat = 50; exp_cnt = 16'd49;
`endif
        set_stim(0, 1, 2, 3, 4, 5, 6, 7);
        push_exp(0, 1, 2, 3, 4, 5, 6, 7);
        load_batch(1'b0, 1'b0);
        wait_out(lat);
        checks++;
        if (lat != exp_lat) begin
            errors++;
            $display("FAIL sorted_latency: got %0d required %0d", lat, exp_lat);
        end
        checks++;
        if (cmp_count !== exp_cnt) begin
            errors++;
            $display("FAIL sorted_cmp_count: got %0d required %0d", cmp_count, exp_cnt);
        end
        drain(1'b0);
        checks++;
        if (cmp_count !== exp_cnt) begin
            errors++;
            $display("FAIL cmp_count_hold: got %0d required %0d", cmp_count, exp_cnt);
        end
    endtask

    initial begin
        test_reset;
        test_unsigned;
        test_signed;
        test_mode_latch;
        test_backpressure;
        test_reset_mid_sort;
        test_early_exit;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
